tri_colour_led_pwm: RTL and testbench

- Downstream stage of the tri-colour LED bus peripheral: consumes that peripheral's 8-bit LED control register value and drives the three physical LED pins.
- Output is PWM-dimmed, with optional blink or breathe effects.
- Control updates are applied only at PWM period boundaries, so the LED outputs never glitch.
- Sits between the LED register and the top-level RGB pins.

---
 rtl/tri_colour_led_pwm_pkg.sv | 40 ++++
 rtl/tri_colour_led_pwm_tick_gen.sv | 33 +++
 rtl/tri_colour_led_pwm.sv | 150 +++++++++++++++
 tb/tb_tri_colour_led_pwm.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_colour_led_pwm_pkg.sv
// Shared encodings for the tri-colour LED PWM stage:
// LED_CTRL field layout, effect modes and effect states.
package tri_colour_led_pwm_pkg;

  localparam int COLOUR_LSB = 0;
  localparam int LEVEL_LSB  = 3;
  localparam int MODE_LSB   = 6;

  typedef enum logic [1:0] {
    MODE_STEADY  = 2'd0,
    MODE_SLOW    = 2'd1,
    MODE_FAST    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_STEADY       = 3'd0,
    ST_BLINK_ON     = 3'd1,
    ST_BLINK_OFF    = 3'd2,
    ST_BREATHE_UP   = 3'd3,
    ST_BREATHE_DOWN = 3'd4
  } state_e;

  typedef struct packed {
    mode_e      mode;
    logic [2:0] level;
    logic [2:0] colour;
  } led_ctrl_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tri_colour_led_pwm_tick_gen.sv
// Prescaler and 3-bit PWM counter for the LED stage.
// Ports: CLK, RESET (sync, high) in; tick, pwm_cnt[2:0], period_wrap out.
module led_pwm_tick_gen #(
  parameter int PRESCALE = 100
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       tick,
  output logic [2:0] pwm_cnt,
  output logic       period_wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  assign tick        = (pre_q == PRE_LAST);
  assign period_wrap = tick && (pwm_cnt == 3'd7);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q   <= '0;
      pwm_cnt <= '0;
    end else if (tick) begin
      pre_q   <= '0;
      pwm_cnt <= pwm_cnt + 3'd1;
    end else begin
      pre_q   <= pre_q + PW'(1);
    end
  end

endmodule

// File: rtl/tri_colour_led_pwm.sv
// PWM-dimmed RGB LED driver with steady/blink/breathe effects.
// Ports: CLK, RESET (sync, high), LED_CTRL[7:0] in;
//        RGB_PWM[2:0] (registered), PERIOD_STROBE out.
import tri_colour_led_pwm_pkg::*;

module tri_colour_led_pwm #(
  parameter int PRESCALE     = 100,
  parameter int BLINK_SLOW   = 62500,
  parameter int BLINK_FAST   = 15625,
  parameter int BREATHE_STEP = 7812
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] LED_CTRL,
  output logic [2:0] RGB_PWM,
  output logic       PERIOD_STROBE
);

  localparam int PH_MAX =
    max3(BLINK_SLOW, BLINK_FAST, BREATHE_STEP);
  localparam int PW = $clog2(PH_MAX + 1);

  localparam logic [PW-1:0] N_SLOW = PW'(BLINK_SLOW);
  localparam logic [PW-1:0] N_FAST = PW'(BLINK_FAST);
  localparam logic [PW-1:0] N_STEP = PW'(BREATHE_STEP);

  logic       tick;
  logic       period_wrap;
  logic       boundary;
  logic [2:0] pwm_cnt;

  led_pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .CLK         (CLK),
    .RESET       (RESET),
    .tick        (tick),
    .pwm_cnt     (pwm_cnt),
    .period_wrap (period_wrap)
  );

  assign boundary      = tick & period_wrap;
  assign PERIOD_STROBE = boundary;

  led_ctrl_t     ctrl_q, ctrl_d, new_c;
  state_e        state_q, state_d;
  logic [2:0]    ramp_q, ramp_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] ph_inc;
  logic [PW-1:0] blink_n;
  logic [2:0]    rgb_d;
  logic [2:0]    eff_level;
  logic          phase_en;
  logic          breathing;

  assign new_c = '{
    mode:   mode_e'(LED_CTRL[MODE_LSB +: 2]),
    level:  LED_CTRL[LEVEL_LSB +: 3],
    colour: LED_CTRL[COLOUR_LSB +: 3]
  };

  assign ph_inc  = phase_q + PW'(1);
  assign blink_n = (ctrl_q.mode == MODE_FAST) ? N_FAST : N_SLOW;

  always_comb begin
    ctrl_d  = ctrl_q;
    state_d = state_q;
    ramp_d  = ramp_q;
    phase_d = phase_q;
    if (boundary) begin
      ctrl_d = new_c;
      if (new_c.mode != ctrl_q.mode) begin
        phase_d = '0;
        ramp_d  = '0;
        unique case (1'b1)
          new_c.mode == MODE_STEADY:
            state_d = ST_STEADY;
          new_c.mode == MODE_BREATHE:
            state_d = ST_BREATHE_UP;
          default:
            state_d = ST_BLINK_ON;
        endcase
      end else begin
        unique case (state_q)
          ST_BLINK_ON, ST_BLINK_OFF: begin
            phase_d = ph_inc;
            if (ph_inc == blink_n) begin
              phase_d = '0;
              state_d = (state_q == ST_BLINK_ON)
                      ? ST_BLINK_OFF : ST_BLINK_ON;
            end
          end
          ST_BREATHE_UP, ST_BREATHE_DOWN: begin
            // A lowered brightness pulls the ramp down at once
            if (new_c.level < ramp_q) begin
              ramp_d  = new_c.level;
              state_d = ST_BREATHE_DOWN;
              phase_d = '0;
            end else begin
              phase_d = ph_inc;
              if (ph_inc == N_STEP) begin
                phase_d = '0;
                if (state_q == ST_BREATHE_UP) begin
                  if (ramp_q != new_c.level) begin
                    ramp_d = ramp_q + 3'd1;
                  end else if (new_c.level != 3'd0) begin
                    state_d = ST_BREATHE_DOWN;
                    ramp_d  = ramp_q - 3'd1;
                  end
                end else if (ramp_q != 3'd0) begin
                  ramp_d = ramp_q - 3'd1;
                end else begin
                  state_d = ST_BREATHE_UP;
                  if (new_c.level != 3'd0) begin
                    ramp_d = 3'd1;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign breathing = (state_q == ST_BREATHE_UP) ||
                     (state_q == ST_BREATHE_DOWN);
  assign eff_level = breathing ? ramp_q : ctrl_q.level;
  assign phase_en  = (state_q != ST_BLINK_OFF);
  assign rgb_d     = ctrl_q.colour &
                     {3{phase_en && (pwm_cnt <= eff_level)}};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q  <= '0;
      state_q <= ST_STEADY;
      ramp_q  <= '0;
      phase_q <= '0;
      RGB_PWM <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      ramp_q  <= ramp_d;
      phase_q <= phase_d;
      RGB_PWM <= rgb_d;
    end
  end

endmodule

// File: tb/tb_tri_colour_led_pwm.sv
// Self-checking bench for tri_colour_led_pwm:
// period-level reference model plus literal duty/effect checks.
module tb_tri_colour_led_pwm;

  localparam int P  = 2;
  localparam int NS = 4;
  localparam int NF = 2;
  localparam int NB = 1;
  localparam int L  = 8 * P;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] LED_CTRL = 8'h00;
  logic [2:0] RGB_PWM;
  logic       PERIOD_STROBE;

  int n_vec = 0;
  int n_err = 0;

  tri_colour_led_pwm #(
    .PRESCALE     (P),
    .BLINK_SLOW   (NS),
    .BLINK_FAST   (NF),
    .BREATHE_STEP (NB)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .LED_CTRL      (LED_CTRL),
    .RGB_PWM       (RGB_PWM),
    .PERIOD_STROBE (PERIOD_STROBE)
  );

  always #5 CLK = ~CLK;

  task automatic check(
    input string      name,
    input logic [7:0] act,
    input logic [7:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: state of the period currently being played
  int         m_mode, m_col, m_lvl;
  int         m_k;
  int         m_ramp, m_step;
  bit         m_up;
  int         c;
  bit         armed = 0;
  logic [2:0] rgb_exp;

  function automatic void model_reset();
    m_mode = 0; m_col = 0; m_lvl = 0;
    m_k = 0; m_ramp = 0; m_step = 0; m_up = 1;
  endfunction

  function automatic logic [2:0] model_rgb(input int pwm);
    int  lvl;
    bit  en;
    lvl = (m_mode == 3) ? m_ramp : m_lvl;
    case (m_mode)
      1:       en = ((m_k / NS) % 2) == 0;
      2:       en = ((m_k / NF) % 2) == 0;
      default: en = 1;
    endcase
    if (en && pwm <= lvl) return 3'(m_col);
    return 3'b000;
  endfunction

  function automatic void next_period(input logic [7:0] v);
    int nm, nl;
    nm = int'(v[7:6]);
    nl = int'(v[5:3]);
    if (nm != m_mode) begin
      m_k = 0; m_ramp = 0; m_up = 1; m_step = 0;
    end else begin
      m_k++;
      if (m_mode == 3) begin
        if (nl < m_ramp) begin
          m_ramp = nl; m_up = 0; m_step = 0;
        end else begin
          m_step++;
          if (m_step == NB) begin
            m_step = 0;
            if (m_up && m_ramp == nl) m_up = (nl == 0);
            else if (!m_up && m_ramp == 0) m_up = 1;
            if (m_up) m_ramp = (m_ramp + 1 > nl) ? nl : m_ramp + 1;
            else      m_ramp = (m_ramp > 0) ? m_ramp - 1 : 0;
          end
        end
      end
    end
    m_mode = nm;
    m_lvl  = nl;
    m_col  = int'(v[2:0]);
  endfunction

  always @(negedge CLK) begin
    if (RESET) begin
      armed = 1;
      c = 0;
      model_reset();
      rgb_exp = 3'b000;
    end else if (armed) begin
      check("rgb_pwm", {5'b0, RGB_PWM}, {5'b0, rgb_exp});
      check("period_strobe", {7'b0, PERIOD_STROBE},
            {7'b0, (c % L) == L - 1});
      rgb_exp = model_rgb((c / P) % 8);
      if ((c % L) == L - 1) next_period(LED_CTRL);
      c++;
    end
  end

  task automatic set_ctrl(input logic [7:0] v);
    @(posedge CLK);
    #1 LED_CTRL = v;
  endtask

  task automatic sync_boundary();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!PERIOD_STROBE && n < 4 * L);
    check("boundary_seen", {7'b0, PERIOD_STROBE}, 8'd1);
    @(negedge CLK);
  endtask

  task automatic apply(input logic [7:0] v);
    set_ctrl(v);
    sync_boundary();
  endtask

  task automatic count_period(
    output int h0,
    output int h1,
    output int h2
  );
    h0 = 0; h1 = 0; h2 = 0;
    repeat (L) begin
      @(negedge CLK);
      h0 += int'(RGB_PWM[0]);
      h1 += int'(RGB_PWM[1]);
      h2 += int'(RGB_PWM[2]);
    end
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  int h0, h1, h2;
  int breathe_exp[8] = '{2, 4, 6, 8, 6, 4, 2, 4};
  int clamp_exp[4]   = '{8, 4, 2, 4};
  logic [7:0] v;

  initial begin
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    apply(8'b00_011_001);
    count_period(h0, h1, h2);
    check("steady_r", 8'(h0), 8'd8);
    check("steady_gb", 8'(h1 + h2), 8'd0);

    apply(8'h3F);
    count_period(h0, h1, h2);
    check("full_r", 8'(h0), 8'd16);
    check("full_g", 8'(h1), 8'd16);
    check("full_b", 8'(h2), 8'd16);

    apply(8'h07);
    count_period(h0, h1, h2);
    check("zero_r", 8'(h0), 8'd2);
    check("zero_g", 8'(h1), 8'd2);
    check("zero_b", 8'(h2), 8'd2);

    set_ctrl(8'h00);
    count_period(h0, h1, h2);
    check("latch_old", 8'(h0 + h1 + h2), 8'd6);
    count_period(h0, h1, h2);
    check("latch_new", 8'(h0 + h1 + h2), 8'd0);

    apply(8'b01_111_010);
    for (int i = 0; i < 8; i++) begin
      count_period(h0, h1, h2);
      check("slow_blink_g", 8'(h1), (i < 4) ? 8'd16 : 8'd0);
    end

    apply(8'b10_111_010);
    for (int i = 0; i < 4; i++) begin
      count_period(h0, h1, h2);
      check("fast_blink_g", 8'(h1), (i < 2) ? 8'd16 : 8'd0);
    end

    apply(8'b11_011_100);
    for (int i = 0; i < 8; i++) begin
      count_period(h0, h1, h2);
      check("breathe_b", 8'(h2), 8'(breathe_exp[i]));
    end

    apply(8'h00);
    apply(8'b11_011_100);
    for (int i = 0; i < 3; i++) begin
      count_period(h0, h1, h2);
      check("clamp_ramp_b", 8'(h2), 8'(breathe_exp[i]));
    end
    set_ctrl(8'b11_001_100);
    for (int i = 0; i < 4; i++) begin
      count_period(h0, h1, h2);
      check("clamp_b", 8'(h2), 8'(clamp_exp[i]));
    end

    apply(8'b01_111_010);
    count_period(h0, h1, h2);
    check("pre_reset_on", 8'(h1), 8'd16);
    pulse_reset();
    @(negedge CLK);
    check("reset_rgb", {5'b0, RGB_PWM}, 8'd0);
    count_period(h0, h1, h2);
    check("reset_latched_zero", 8'(h0 + h1 + h2), 8'd0);
    count_period(h0, h1, h2);
    check("reset_resample_on", 8'(h1), 8'd16);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_reset();
      end else begin
        v = 8'($urandom);
        if ($urandom_range(0, 1) == 1) v[7:6] = LED_CTRL[7:6];
        set_ctrl(v);
      end
      repeat ($urandom_range(1, 50)) @(posedge CLK);
    end
    repeat (3 * L) @(posedge CLK);
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
